// File: rtl/loop_sched_pkg.sv
// Shared types and constants for the loop scheduler and its arbiter.
package loop_sched_pkg;

    // Number of requesters sharing the loop datapath.
    localparam int NUM_REQ = 2;

    // Default datapath width of the loop index, accumulator and bounds.
    localparam int W_DEF = 10;

    // Scheduler control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : loop_sched_pkg

// File: rtl/loop_sched_rr_arb2.sv
// Two-way round-robin arbiter. The grant is combinational from the live
// requests; the priority pointer moves away from the last owner whenever
// the update strobe fires (once per completed loop).
module rr_arb2
    import loop_sched_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               upd,
    input  logic               last,
    output logic [NUM_REQ-1:0] grant
);

    // Index of the requester that wins a tie; 0 out of reset.
    logic ptr;

    // Move priority to the requester that was not served last.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= 1'b0;
        end else if (upd) begin
            ptr <= ~last;
        end
    end

    // One-hot grant: a lone requester always wins, a tie goes to ptr.
    // NOTE: the default assignment first guarantees no latch is inferred.
    always_comb begin
        grant = '0;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr ? 2'b10 : 2'b01;
            default: grant = '0;
        endcase
    end

endmodule : rr_arb2

// File: rtl/loop_sched.sv
// Shares one counting loop (index i, accumulator sn) between two
// requesters. IDLE arbitrates, RUN counts up to the latched bound while
// selector is high, DONE pulses completion to the owner.
// Optional macro LOOP_SCHED_CHECK_EN compiles in an invariant monitor that
// drives the sticky err flag; without it err is tied low.
module loop_sched
    import loop_sched_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [W-1:0]       n0,
    input  logic [W-1:0]       n1,
    input  logic               selector,
    output logic [NUM_REQ-1:0] ack,
    output logic               busy,
    output logic               owner,
    output logic [W-1:0]       i,
    output logic [W-1:0]       sn,
    output logic [NUM_REQ-1:0] done,
    output logic               err
);

    state_t             state;
    logic [W-1:0]       bound;
    logic [NUM_REQ-1:0] grant;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .upd   (state == DONE),
        .last  (owner),
        .grant (grant)
    );

    // Control FSM with registered pulses, bound latch and loop counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            ack   <= '0;
            done  <= '0;
            busy  <= 1'b0;
            owner <= 1'b0;
            bound <= '0;
            i     <= '0;
            sn    <= '0;
        end else begin
            ack  <= '0;
            done <= '0;
            case (state)
                IDLE: begin
                    if (|grant) begin
                        owner <= grant[1];
                        bound <= grant[1] ? n1 : n0;
                        i     <= '0;
                        sn    <= '0;
                        ack   <= grant;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // Stopping at the bound keeps i and sn from wrapping.
                    if (i == bound) begin
                        done  <= owner ? 2'b10 : 2'b01;
                        state <= DONE;
                    end else if (selector) begin
                        i  <= i + W'(1);
                        sn <= sn + W'(1);
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef LOOP_SCHED_CHECK_EN
    // Sticky flag for a loop that lost lock-step or overran its bound.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else if (state == RUN && (sn != i || i > bound)) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule : loop_sched
